round_robin_arbiter: RTL and testbench

Fair N-way round-robin arbiter that shares a single downstream resource among N requesters. Each cycle it picks one request, rotating priority to the position after the previous winner. It presents the winner as a registered one-hot grant plus its binary index. Priority selection is built on the one-hot lowest-index priority encoder in the coders library; this block adds the state, rotating mask and grant handshake around it.

---
 rtl/arbiter_pkg.sv | 22 ++
 rtl/onehot_priority_encoder.sv | 14 +
 rtl/round_robin_arbiter.sv | 104 ++++++++++
 tb/tb_round_robin_arbiter.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/arbiter_pkg.sv
// Shared types and helpers for the round-robin arbiter.
package arbiter_pkg;

  localparam int unsigned OH_MAX_W = 64;
  localparam int unsigned OH_IDX_W = $clog2(OH_MAX_W);

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  // Binary index of a one-hot vector (zero for an all-zero vector).
  function automatic logic [OH_IDX_W-1:0] onehot_to_idx(input logic [OH_MAX_W-1:0] oh);
    logic [OH_IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < OH_MAX_W; i++) begin
      if (oh[i]) idx = idx | OH_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/onehot_priority_encoder.sv
// One-hot lowest-index priority encoder: isolates the lowest set bit of i_in.
module onehot_priority_encoder #(
  parameter int unsigned IW = 4
) (
  input  logic [IW-1:0] i_in,
  output logic [IW-1:0] o_onehot,
  output logic          o_valid
);

  // Two's-complement trick keeps only the lowest set bit.
  assign o_onehot = i_in & (~i_in + IW'(1));
  assign o_valid  = |i_in;

endmodule

// File: rtl/round_robin_arbiter.sv
// N-way round-robin arbiter with registered one-hot grant and index.
// Optional grant locking is enabled by defining ROUND_ROBIN_ARBITER_LOCK_EN.
module round_robin_arbiter
  import arbiter_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned IDXW = $clog2(N)
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic [N-1:0]    i_req,
  output logic [N-1:0]    o_gnt,
  output logic            o_gnt_valid,
  output logic [IDXW-1:0] o_gnt_idx
);

  arb_state_e      state_q, state_d;
  logic [IDXW-1:0] last_q, last_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [IDXW-1:0] gnt_idx_q, gnt_idx_d;

  logic [N-1:0]    mask_c;
  logic [N-1:0]    hi_c;
  logic [N-1:0]    hi_oh_c;
  logic            hi_valid_c;
  logic [N-1:0]    raw_oh_c;
  logic            raw_valid_c;
  logic [N-1:0]    winner_c;
  logic [IDXW-1:0] winner_idx_c;
  logic            hold_c;

  // Rotating mask: only positions strictly after the last winner.
  always_comb begin
    mask_c = '0;
    for (int unsigned k = 0; k < N; k++) begin
      mask_c[k] = (k > 32'(last_q));
    end
  end

  assign hi_c = i_req & mask_c;

  onehot_priority_encoder #(.IW(N)) u_enc_masked (
    .i_in     (hi_c),
    .o_onehot (hi_oh_c),
    .o_valid  (hi_valid_c)
  );

  onehot_priority_encoder #(.IW(N)) u_enc_raw (
    .i_in     (i_req),
    .o_onehot (raw_oh_c),
    .o_valid  (raw_valid_c)
  );

  // Masked path wins when it has any request; otherwise wrap to the raw path.
  assign winner_c     = hi_valid_c ? hi_oh_c : raw_oh_c;
  assign winner_idx_c = IDXW'(onehot_to_idx(OH_MAX_W'(winner_c)));

`ifdef ROUND_ROBIN_ARBITER_LOCK_EN
  // Current owner keeps the grant while its request stays high.
  assign hold_c = (state_q == ARB_GRANT) && i_req[gnt_idx_q];
`else
  assign hold_c = 1'b0;
`endif

  // Next-state and next-grant selection.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    gnt_idx_d = gnt_idx_q;
    if (hold_c) begin
      state_d = ARB_GRANT;
    end else if (raw_valid_c) begin
      state_d   = ARB_GRANT;
      gnt_d     = winner_c;
      gnt_idx_d = winner_idx_c;
      last_d    = winner_idx_c;
    end else begin
      state_d   = ARB_IDLE;
      gnt_d     = '0;
      gnt_idx_d = '0;
    end
  end

  // State and output registers; reset makes requester 0 top priority.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q   <= ARB_IDLE;
      last_q    <= IDXW'(N - 1);
      gnt_q     <= '0;
      gnt_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      gnt_idx_q <= gnt_idx_d;
    end
  end

  assign o_gnt       = gnt_q;
  assign o_gnt_valid = (state_q == ARB_GRANT);
  assign o_gnt_idx   = gnt_idx_q;

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Self-checking bench for round_robin_arbiter (N=4) against a circular-scan model.
module tb_round_robin_arbiter;

  localparam int unsigned N    = 4;
  localparam int unsigned IDXW = 2;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req;
  logic [N-1:0]    gnt;
  logic            gnt_valid;
  logic [IDXW-1:0] gnt_idx;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int           m_last;
  logic [N-1:0] m_gnt;
  int           m_idx;
  logic [N-1:0] prev_req;

  round_robin_arbiter #(.N(N)) dut (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_req       (req),
    .o_gnt       (gnt),
    .o_gnt_valid (gnt_valid),
    .o_gnt_idx   (gnt_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Model: search circularly from the position after the last winner.
  task automatic model_edge(input logic r, input logic [N-1:0] rq);
    int w;
    bit locked;
    if (r) begin
      m_last = N - 1;
      m_gnt  = '0;
      m_idx  = 0;
    end else begin
      locked = 1'b0;
`ifdef ROUND_ROBIN_ARBITER_LOCK_EN
      locked = (m_gnt != 0) && rq[m_idx];
`endif
      if (!locked) begin
        if (rq == 0) begin
          m_gnt = '0;
          m_idx = 0;
        end else begin
          w = -1;
          for (int off = 1; off <= int'(N); off++) begin
            int k;
            k = (m_last + off) % N;
            if (w < 0 && rq[k]) w = k;
          end
          m_gnt  = '0;
          m_gnt[w] = 1'b1;
          m_idx  = w;
          m_last = w;
        end
      end
    end
  endtask

  // Apply one cycle of inputs and compare all outputs with the model.
  task automatic step(input logic r, input logic [N-1:0] rq, input string tag);
    rst = r;
    req = rq;
    @(posedge clk);
    model_edge(r, rq);
    #1;
    check({tag, ".gnt"},   32'(gnt),       32'(m_gnt));
    check({tag, ".valid"}, 32'(gnt_valid), 32'(m_gnt != 0));
    check({tag, ".idx"},   32'(gnt_idx),   32'(m_idx));
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    m_last = N - 1;
    m_gnt  = '0;
    m_idx  = 0;

    // Reset held with all requests
    for (int i = 0; i < 3; i++) step(1'b1, 4'b1111, "reset");
    check("reset.gnt_const", 32'(gnt), 32'h0);

    // First grant after release goes to requester 0
    step(1'b0, 4'b1111, "release");
    check("release.gnt_const", 32'(gnt), 32'h1);

    // Fair rotation with all requesting
    for (int i = 0; i < 4; i++) step(1'b0, 4'b1111, "rotate");
`ifndef ROUND_ROBIN_ARBITER_LOCK_EN
    check("rotate.wrap_const", 32'(gnt), 32'h1);
    step(1'b0, 4'b1111, "to_bit1");
    check("to_bit1.const", 32'(gnt), 32'h2);
    // Skipping and wrap
    step(1'b0, 4'b1010, "skip");
    check("skip.const", 32'(gnt), 32'h8);
    step(1'b0, 4'b1010, "skip");
    check("skip_wrap.const", 32'(gnt), 32'h2);
    step(1'b0, 4'b1010, "skip");
    // Idle retention: win bit 2, idle two cycles, then wrap to bit 0
    step(1'b0, 4'b0100, "win2");
    step(1'b0, 4'b0000, "idle");
    check("idle.valid_const", 32'(gnt_valid), 32'h0);
    step(1'b0, 4'b0000, "idle");
    step(1'b0, 4'b0101, "after_idle");
    check("after_idle.const", 32'(gnt), 32'h1);
    // Single requester granted every cycle
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0100, "single");
`else
    // Lock: owner 0 holds grant while its request stays high
    step(1'b1, 4'b0000, "lreset");
    for (int i = 0; i < 5; i++) step(1'b0, 4'b0011, "lock_hold");
    check("lock_hold.const", 32'(gnt), 32'h1);
    step(1'b0, 4'b0010, "lock_drop");
    check("lock_drop.const", 32'(gnt), 32'h2);
    // Reset mid-grant
    step(1'b0, 4'b0100, "lgrant2");
    step(1'b0, 4'b0100, "lgrant2");
    step(1'b1, 4'b0100, "lmidreset");
    check("lmidreset.const", 32'(gnt), 32'h0);
    step(1'b0, 4'b0100, "lafter");
    check("lafter.const", 32'(gnt), 32'h4);
`endif

    // Reset mid-grant (both builds)
    step(1'b1, 4'b1111, "midreset");
    step(1'b0, 4'b0100, "post_reset");

    // Randomized traffic; sometimes repeat the previous vector to exercise holds
    prev_req = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] rq;
      logic         r;
      if ($urandom_range(0, 3) == 0) rq = prev_req;
      else rq = N'($urandom_range(0, 15));
      r = ($urandom_range(0, 49) == 0);
      prev_req = rq;
      step(r, rq, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
